// File: rtl/nibble_add_pkg.sv
//==============================================================================
// Module      : nibble_add_pkg
// Description : Shared state encodings and helper functions for the
//               nibble-serial add/subtract sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package nibble_add_pkg;

  // Width of one adder slice
  localparam int c_nib_bits = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width needed to count 0..nib-1 (at least one bit)
  function automatic int nib_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parallel_4_bit_adder.sv
//==============================================================================
// Module      : parallel_4_bit_adder
// Description : Purely combinational 4-bit ripple-carry adder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module parallel_4_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  // One full adder per bit, carry rippling upward
  generate
    for (genvar g = 0; g < 4; g++) begin : g_fa
      assign sum[g]   = a[g] ^ b[g] ^ w_c[g];
      assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
    end
  endgenerate

  assign cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
//==============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Adds or subtracts WIDTH-bit operands through one shared 4-bit
//               adder, one nibble per clock, LSB nibble first, with
//               valid/ready handshakes on the operand and result sides.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIB   = WIDTH / c_nib_bits;
  localparam int NIB_W = nib_w(NIB);
  localparam int MSB   = WIDTH - 1;
  localparam logic [NIB_W-1:0] c_last_idx = NIB_W'(NIB - 1);

  state_t           r_state;
  logic [NIB_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [3:0]       w_a_nibs [NIB];
  logic [3:0]       w_b_nibs [NIB];
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_nib_sum;
  logic             w_nib_cout;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  // Split the held operands into nibbles for the adder input muxes
  generate
    for (genvar g = 0; g < NIB; g++) begin : g_nib_split
      assign w_a_nibs[g] = r_a[g*c_nib_bits +: c_nib_bits];
      assign w_b_nibs[g] = r_b[g*c_nib_bits +: c_nib_bits];
    end
  endgenerate

  assign w_a_nib = w_a_nibs[r_idx];
  assign w_b_nib = w_b_nibs[r_idx];

  parallel_4_bit_adder u_adder (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_step   = (r_state == RUN);
  assign w_last   = w_step && (r_idx == c_last_idx);

  // Sequencer: state, nibble index and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state    <= RUN;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          // Index holds at the last nibble rather than wrapping
          if (r_idx == c_last_idx) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + NIB_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: capture operands on acceptance, then accumulate one nibble per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b once and seed the carry with 1
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub | cin;
    end else if (w_step) begin
      r_carry <= w_nib_cout;
      for (int i = 0; i < NIB; i++) begin
        if (r_idx == NIB_W'(i)) begin
          r_sum[i*c_nib_bits +: c_nib_bits] <= w_nib_sum;
        end
      end
      if (w_last) begin
        r_cout <= w_nib_cout;
        // Same-sign inputs producing an opposite-sign result overflowed
        r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_nib_sum[3] != r_a[MSB]);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
//==============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl: directed
//               corner cases plus randomized ops against an arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {cout, overflow, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    if (!msub) begin
      s  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
      r  = s[W-1:0];
      co = s[W];
      ov = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    end else begin
      r  = ma - mb;
      co = (ma >= mb);
      ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    end
    return {co, ov, r};
  endfunction

  // One full transaction; noise drives junk on the input side while busy
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                        input logic tcin, input logic tsub, input bit noise,
                        input int out_stall, output logic [W-1:0] rs,
                        output logic rc, output logic rov);
    int lat;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      @(posedge clk); lat++; #1;
      if (out_valid || lat >= 4 * NIB + 8) break;
    end
    check("latency", 32'(lat), 32'(NIB));
    rs = sum; rc = cout; rov = overflow;
    for (int k = 0; k < out_stall; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(rs));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         rov;
    logic [W+1:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rcin;
    logic         rsub;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted while the op is at nibble index 2
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, rs, rc, rov);
    check("add_carry_sum", 32'(rs), 32'h0100);
    check("add_carry_cout", 32'(rc), 32'd0);
    check("add_carry_ovf", 32'(rov), 32'd0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, rs, rc, rov);
    check("add_wrap_sum", 32'(rs), 32'h0000);
    check("add_wrap_cout", 32'(rc), 32'd1);
    check("add_wrap_ovf", 32'(rov), 32'd0);

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, rs, rc, rov);
    check("add_ovf_sum", 32'(rs), 32'h8000);
    check("add_ovf_cout", 32'(rc), 32'd0);
    check("add_ovf_ovf", 32'(rov), 32'd1);

    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0, rs, rc, rov);
    check("sub_neg_sum", 32'(rs), 32'hFFFE);
    check("sub_neg_cout", 32'(rc), 32'd0);
    check("sub_neg_ovf", 32'(rov), 32'd0);

    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 0, rs, rc, rov);
    check("sub_ovf_sum", 32'(rs), 32'h7FFF);
    check("sub_ovf_cout", 32'(rc), 32'd1);
    check("sub_ovf_ovf", 32'(rov), 32'd1);

    // Backpressure in DONE with a new op waiting on the input side
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (NIB) @(posedge clk);
    #1;
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_sum", 32'(sum), 32'h2345);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h2345);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_next_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    repeat (NIB) @(posedge clk);
    #1;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_sum", 32'(sum), 32'h0E0E);
    check("bp_next_cout", 32'(cout), 32'd1);
    check("bp_next_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized ops with input/output stalls and junk inputs while busy
    for (int n = 0; n < 1000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      exp  = model(ra, rb, rcin, rsub);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, rcin, rsub, 1'b1, int'($urandom_range(0, 3)), rs, rc, rov);
      check("rand_sum", 32'(rs), 32'(exp[W-1:0]));
      check("rand_ovf", 32'(rov), 32'(exp[W]));
      check("rand_cout", 32'(rc), 32'(exp[W+1]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
